res_station: RTL and testbench
==============================

// Module: res_station
// PURPOSE
// Reservation station feeding the issue stage: buffers dispatched instructions, captures missing operands
// from the common data bus (CDB), and each cycle selects ready entries onto the three issue lines.
// Lines 1/2 feed the two ALU units (R/I-type arithmetic); line 3 feeds the memory unit (LW/SW).
// Respects the per-unit busy vector func_units, matching the issue stage's line_1..3 / func_units interface.
// PARAMETERS
// DEPTH   8   number of entries (power of 2 not required, >=3)
// TAG_W   6   width of producer tags carried by CDB and source operands
// PORTS
// clk           in   1       clock, all state on posedge
// rst           in   1       asynchronous active-high reset
// disp_valid    in   1       dispatch request
// disp_ready    out  1       station can accept; = (count < DEPTH)
// disp_entry    in   res_entry  opcode, alu_op, source_1, source_2, imm, dest_tag of new instruction
// disp_s1_rdy   in   1       source_1 value valid at dispatch
// disp_s1_tag   in   TAG_W   producer tag of source_1 when not ready
// disp_s2_rdy   in   1       source_2 value valid at dispatch
// disp_s2_tag   in   TAG_W   producer tag of source_2 when not ready
// cdb_valid     in   1       result broadcast valid
// cdb_tag       in   TAG_W   broadcast producer tag
// cdb_value     in   32      broadcast value
// func_units    in   3       bit i = unit i busy; busy unit receives no issue
// line_1/2/3    out  res_entry  issued entry for ALU0, ALU1, MEM
// line_valid    out  3       bit i = line_(i+1) holds a new issue this cycle
// flush         in   1       clear all entries (RS_FLUSH_EN only)
// BEHAVIOUR
// - Reset: all entries invalid, count=0, line_valid=0, line_1..3 all-zero; disp_ready=1 after reset.
// - Storage is age-ordered: slot 0 oldest; issued slots removed and younger entries compact down same edge.
// - Dispatch: disp_valid&disp_ready at edge N writes entry into lowest free slot; eligible for select at N+1.
// - Class: opcode 0110011/0010011 -> ALU; 0000011/0100011 -> MEM; any other opcode -> dropped at dispatch
//   (no slot used, count unchanged).
// - Operand need: R-type and SW need s1 and s2; I-type (ADDI/ANDI) and LW need s1 only; s2 marked ready.
// - Wakeup: cdb_valid at edge N writes cdb_value into every waiting source whose tag==cdb_tag, sets ready.
//   Same-cycle dispatch with matching not-ready tag also captures (bypass). Woken entry selectable at N+1.
// - Ready entry = valid & all needed sources ready. Select uses registered state only (no CDB-to-issue path).
// - Select per cycle: oldest ready ALU entry -> line_1 if ~func_units[0]; next-oldest ready ALU entry ->
//   line_2 if ~func_units[1] (if unit 0 busy, oldest goes to line_2); oldest ready MEM entry -> line_3
//   if ~func_units[2]. Max 3 issues/cycle, at most one entry per line.
// - Issue latency: selection at cycle N registers line_x and line_valid at edge N+1; entry freed same edge.
// - line_x holds its last value when line_valid bit is 0; consumers qualify with line_valid.
// - Simultaneous dispatch+issue when full: disp_ready based on count before the edge; no same-cycle reuse.
// - count = number of valid entries; never exceeds DEPTH; dispatch while !disp_ready ignored.
// - rst asserted mid-operation: entries and outputs cleared immediately, in-flight dispatch lost.
// CONFIGURATION
// RS_FLUSH_EN defined: flush=1 at an edge invalidates all entries, count=0, line_valid=0 that edge;
//   flush has priority over dispatch, wakeup and issue in that cycle.
// RS_FLUSH_EN undefined: flush port present but ignored; no flush logic synthesized.
// TESTING
// 1. Dispatch ADD(s1=5,s2=7 ready), func_units=000 -> next edge line_1.source_1=5,source_2=7, line_valid=001.
// 2. Dispatch LW s1 waiting tag 3; cdb tag3 value 0x40 -> line_3.source_1=0x40 one edge after wakeup, bit2=1.
// 3. Three ready ALU ops A,B,C, func_units=000 -> A on line_1, B on line_2; C issues next cycle on line_1.
// 4. Fill 8 entries all waiting -> disp_ready=0, 9th dispatch ignored, count stays 8.
// 5. func_units=001 with one ready ALU op -> issues on line_2, line_valid=010.
// 6. RS_FLUSH_EN: 4 entries held, flush=1 -> count=0, disp_ready=1, no issue following cycle.

Source files
------------

// File: rtl/res_station_if.sv
// Shared types for the reservation station and the interface bundling its
// dispatch, CDB broadcast and issue-line signals.
// Tag width is fixed here because the entry type carries a producer tag.

package res_station_pkg;
   localparam int TAG_W = 6;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   typedef struct packed {
      logic [6:0]       opcode;
      logic [3:0]       alu_op;
      logic [31:0]      source_1;
      logic [31:0]      source_2;
      logic [31:0]      imm;
      logic [TAG_W-1:0] dest_tag;
   } res_entry;
endpackage

interface res_station_if;
   import res_station_pkg::*;

   logic             disp_valid;
   logic             disp_ready;
   res_entry         disp_entry;
   logic             disp_s1_rdy;
   logic [TAG_W-1:0] disp_s1_tag;
   logic             disp_s2_rdy;
   logic [TAG_W-1:0] disp_s2_tag;
   logic             cdb_valid;
   logic [TAG_W-1:0] cdb_tag;
   logic [31:0]      cdb_value;
   logic [2:0]       func_units;
   logic             flush;
   res_entry         line_1;
   res_entry         line_2;
   res_entry         line_3;
   logic [2:0]       line_valid;

   // Dispatch/CDB/issue-stage side.
   modport master (
      output disp_valid, disp_entry, disp_s1_rdy, disp_s1_tag, disp_s2_rdy, disp_s2_tag,
      output cdb_valid, cdb_tag, cdb_value, func_units, flush,
      input  disp_ready, line_1, line_2, line_3, line_valid
   );

   // Reservation station side.
   modport slave (
      input  disp_valid, disp_entry, disp_s1_rdy, disp_s1_tag, disp_s2_rdy, disp_s2_tag,
      input  cdb_valid, cdb_tag, cdb_value, func_units, flush,
      output disp_ready, line_1, line_2, line_3, line_valid
   );
endinterface

// File: rtl/res_station.sv
// Reservation station: age-ordered buffer of dispatched instructions that
// captures operands from the CDB and issues up to two ALU entries and one MEM
// entry per cycle onto line_1/line_2/line_3.
// Optional feature: define RS_FLUSH_EN to make the flush input clear all
// entries; without it the flush input is ignored.

module res_station
   import res_station_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input logic          clk,
   input logic          rst,
   res_station_if.slave bus
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef struct packed {
      logic             valid;
      logic             is_mem;
      logic             s1_rdy;
      logic             s2_rdy;
      logic [TAG_W-1:0] s1_tag;
      logic [TAG_W-1:0] s2_tag;
      res_entry         e;
   } slot_t;

   slot_t            slots     [DEPTH];
   slot_t            slots_nxt [DEPTH];
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_nxt;
   logic             can_accept;

   logic [DEPTH-1:0] ready;
   logic             alu0_found, alu1_found, mem_found;
   logic [IDX_W-1:0] alu0_idx, alu1_idx, mem_idx;
   logic             l1_go, l2_go, l3_go;
   logic [IDX_W-1:0] l2_idx;
   logic [DEPTH-1:0] issue;

   logic             is_alu_op, is_mem_op, need_s2, disp_take;
   slot_t            disp_slot;

   // Full check uses the count before the edge, so a slot freed by issue
   // this cycle cannot be reused until the next one.
   assign can_accept     = (count < CNT_W'(DEPTH));
   assign bus.disp_ready = can_accept;

   // Find the two oldest ready ALU entries and the oldest ready MEM entry
   // from registered state only.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned and a latch cannot be inferred.
      ready      = '0;
      alu0_found = 1'b0;
      alu1_found = 1'b0;
      mem_found  = 1'b0;
      alu0_idx   = '0;
      alu1_idx   = '0;
      mem_idx    = '0;
      for (int i = 0; i < DEPTH; i++) begin
         ready[i] = slots[i].valid & slots[i].s1_rdy & slots[i].s2_rdy;
         if (ready[i] && !slots[i].is_mem) begin
            if (!alu0_found) begin
               alu0_found = 1'b1;
               alu0_idx   = IDX_W'(i);
            end else if (!alu1_found) begin
               alu1_found = 1'b1;
               alu1_idx   = IDX_W'(i);
            end
         end
         if (ready[i] && slots[i].is_mem && !mem_found) begin
            mem_found = 1'b1;
            mem_idx   = IDX_W'(i);
         end
      end
   end

   // Route candidates to free units; when ALU0 is busy the oldest ALU entry
   // moves to line_2.
   always_comb begin
      l1_go = alu0_found & ~bus.func_units[0];
      if (bus.func_units[0]) begin
         l2_go  = alu0_found & ~bus.func_units[1];
         l2_idx = alu0_idx;
      end else begin
         l2_go  = alu1_found & ~bus.func_units[1];
         l2_idx = alu1_idx;
      end
      l3_go = mem_found & ~bus.func_units[2];
      issue = '0;
      if (l1_go) issue[alu0_idx] = 1'b1;
      if (l2_go) issue[l2_idx]   = 1'b1;
      if (l3_go) issue[mem_idx]  = 1'b1;
   end

   // Decode the incoming instruction, drop unsupported opcodes, and let a
   // same-cycle CDB broadcast fill a missing operand.
   always_comb begin
      is_alu_op = (bus.disp_entry.opcode == OP_R) || (bus.disp_entry.opcode == OP_I);
      is_mem_op = (bus.disp_entry.opcode == OP_LOAD) || (bus.disp_entry.opcode == OP_STORE);
      need_s2   = (bus.disp_entry.opcode == OP_R) || (bus.disp_entry.opcode == OP_STORE);
      disp_take = bus.disp_valid & can_accept & (is_alu_op | is_mem_op);

      disp_slot.valid  = 1'b1;
      disp_slot.is_mem = is_mem_op;
      disp_slot.s1_rdy = bus.disp_s1_rdy;
      disp_slot.s1_tag = bus.disp_s1_tag;
      disp_slot.s2_rdy = need_s2 ? bus.disp_s2_rdy : 1'b1;
      disp_slot.s2_tag = bus.disp_s2_tag;
      disp_slot.e      = bus.disp_entry;
      if (bus.cdb_valid && !disp_slot.s1_rdy && (disp_slot.s1_tag == bus.cdb_tag)) begin
         disp_slot.e.source_1 = bus.cdb_value;
         disp_slot.s1_rdy     = 1'b1;
      end
      if (bus.cdb_valid && !disp_slot.s2_rdy && (disp_slot.s2_tag == bus.cdb_tag)) begin
         disp_slot.e.source_2 = bus.cdb_value;
         disp_slot.s2_rdy     = 1'b1;
      end
   end

   // Wake waiting sources, squeeze out issued entries toward slot 0, then
   // append the new dispatch just above the survivors.
   always_comb begin
      int    wr;
      slot_t woke;
      wr = 0;
      for (int i = 0; i < DEPTH; i++) slots_nxt[i] = '0;
      for (int i = 0; i < DEPTH; i++) begin
         woke = slots[i];
         if (bus.cdb_valid && !woke.s1_rdy && (woke.s1_tag == bus.cdb_tag)) begin
            woke.e.source_1 = bus.cdb_value;
            woke.s1_rdy     = 1'b1;
         end
         if (bus.cdb_valid && !woke.s2_rdy && (woke.s2_tag == bus.cdb_tag)) begin
            woke.e.source_2 = bus.cdb_value;
            woke.s2_rdy     = 1'b1;
         end
         if (woke.valid && !issue[i]) begin
            slots_nxt[wr] = woke;
            wr++;
         end
      end
      if (disp_take && (wr < DEPTH)) slots_nxt[wr] = disp_slot;
      count_nxt = CNT_W'(wr) + CNT_W'(disp_take);
   end

   // Register storage, occupancy and issue lines; flush (when built in) wins
   // over wakeup, issue and dispatch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the entry array is reset, not just the count, because the
         // valid bits decide issue and the lines must read zero after reset.
         for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
         count          <= '0;
         bus.line_valid <= '0;
         bus.line_1     <= '0;
         bus.line_2     <= '0;
         bus.line_3     <= '0;
      end
`ifdef RS_FLUSH_EN
      else if (bus.flush) begin
         for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
         count          <= '0;
         bus.line_valid <= '0;
      end
`endif
      else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge state regardless of statement order.
         for (int i = 0; i < DEPTH; i++) slots[i] <= slots_nxt[i];
         count          <= count_nxt;
         bus.line_valid <= {l3_go, l2_go, l1_go};
         if (l1_go) bus.line_1 <= slots[alu0_idx].e;
         if (l2_go) bus.line_2 <= slots[l2_idx].e;
         if (l3_go) bus.line_3 <= slots[mem_idx].e;
      end
   end
endmodule

// File: tb/tb_res_station.sv
// Directed bench for res_station: stimulus pushes the expected issued entry
// per line into a queue; a monitor pops and compares whenever line_valid is set.

module tb_res_station;
   import res_station_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   res_station_if bus ();

   res_station #(.DEPTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int       n_checks = 0;
   int       n_errors = 0;
   res_entry q1[$];
   res_entry q2[$];
   res_entry q3[$];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic res_entry mk(input logic [6:0] op, input logic [31:0] s1,
                                   input logic [31:0] s2, input logic [5:0] tag);
      res_entry e;
      e          = '0;
      e.opcode   = op;
      e.alu_op   = tag[3:0];
      e.source_1 = s1;
      e.source_2 = s2;
      e.imm      = 32'h1000 + 32'(tag);
      e.dest_tag = tag;
      return e;
   endfunction

   task automatic dispatch(input res_entry e, input logic s1r, input logic [5:0] s1t,
                           input logic s2r, input logic [5:0] s2t);
      bus.disp_valid  = 1'b1;
      bus.disp_entry  = e;
      bus.disp_s1_rdy = s1r;
      bus.disp_s1_tag = s1t;
      bus.disp_s2_rdy = s2r;
      bus.disp_s2_tag = s2t;
      @(posedge clk);
      #1;
      bus.disp_valid  = 1'b0;
   endtask

   // Scoreboard monitor: one pop per asserted line_valid bit.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.line_valid[0]) begin
            if (q1.size() == 0) begin
               n_checks++; n_errors++;
               $display("FAIL line1_unexpected: got %h expected no issue", bus.line_1);
            end else check("line1", bus.line_1, q1.pop_front());
         end
         if (bus.line_valid[1]) begin
            if (q2.size() == 0) begin
               n_checks++; n_errors++;
               $display("FAIL line2_unexpected: got %h expected no issue", bus.line_2);
            end else check("line2", bus.line_2, q2.pop_front());
         end
         if (bus.line_valid[2]) begin
            if (q3.size() == 0) begin
               n_checks++; n_errors++;
               $display("FAIL line3_unexpected: got %h expected no issue", bus.line_3);
            end else check("line3", bus.line_3, q3.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no end of test expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      res_entry a, b, c, d, ex;

      rst = 1'b1;
      bus.disp_valid = 1'b0; bus.disp_entry = '0;
      bus.disp_s1_rdy = 1'b0; bus.disp_s1_tag = '0;
      bus.disp_s2_rdy = 1'b0; bus.disp_s2_tag = '0;
      bus.cdb_valid = 1'b0; bus.cdb_tag = '0; bus.cdb_value = '0;
      bus.func_units = 3'b000; bus.flush = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      check("rst_disp_ready", bus.disp_ready, 1);
      check("rst_line_valid", bus.line_valid, 0);
      check("rst_line_1", bus.line_1, 0);
      check("rst_line_3", bus.line_3, 0);

      // ADD with both operands ready issues on line_1 one edge after dispatch.
      a = mk(OP_R, 32'd5, 32'd7, 6'd1);
      q1.push_back(a);
      dispatch(a, 1'b1, 6'd0, 1'b1, 6'd0);
      @(negedge clk); check("t1_early", bus.line_valid, 3'b000);
      @(negedge clk); check("t1_lv", bus.line_valid, 3'b001);

      // LW waiting on tag 3; CDB wakes it, issue on line_3 one edge later.
      a = mk(OP_LOAD, 32'd0, 32'd0, 6'd2);
      ex = a; ex.source_1 = 32'h40;
      q3.push_back(ex);
      dispatch(a, 1'b0, 6'd3, 1'b0, 6'd7);
      bus.cdb_valid = 1'b1; bus.cdb_tag = 6'd3; bus.cdb_value = 32'h40;
      @(posedge clk); #1;
      bus.cdb_valid = 1'b0;
      @(negedge clk); check("t2_wake_edge", bus.line_valid, 3'b000);
      @(negedge clk); check("t2_lv", bus.line_valid, 3'b100);

      // SW dispatched in the same cycle as the CDB broadcast of its s2 tag.
      a = mk(OP_STORE, 32'h100, 32'd0, 6'd3);
      ex = a; ex.source_2 = 32'hABCD;
      q3.push_back(ex);
      bus.cdb_valid = 1'b1; bus.cdb_tag = 6'd9; bus.cdb_value = 32'hABCD;
      dispatch(a, 1'b1, 6'd0, 1'b0, 6'd9);
      bus.cdb_valid = 1'b0;
      @(negedge clk); check("t2b_early", bus.line_valid, 3'b000);
      @(negedge clk); check("t2b_lv", bus.line_valid, 3'b100);

      // ADDI does not wait on s2 even when its s2 tag is marked not ready.
      a = mk(OP_I, 32'd3, 32'd0, 6'd4);
      q1.push_back(a);
      dispatch(a, 1'b1, 6'd0, 1'b0, 6'd12);
      @(negedge clk);
      @(negedge clk); check("t_addi_lv", bus.line_valid, 3'b001);

      // Three ready ALU ops: oldest two issue together, third next cycle.
      bus.func_units = 3'b111;
      a = mk(OP_R, 32'd10, 32'd11, 6'd5);
      b = mk(OP_R, 32'd20, 32'd21, 6'd6);
      c = mk(OP_R, 32'd30, 32'd31, 6'd7);
      q1.push_back(a); q2.push_back(b); q1.push_back(c);
      dispatch(a, 1'b1, 6'd0, 1'b1, 6'd0);
      dispatch(b, 1'b1, 6'd0, 1'b1, 6'd0);
      dispatch(c, 1'b1, 6'd0, 1'b1, 6'd0);
      bus.func_units = 3'b000;
      @(negedge clk); check("t3_hold", bus.line_valid, 3'b000);
      @(negedge clk); check("t3_first", bus.line_valid, 3'b011);
      @(negedge clk); check("t3_second", bus.line_valid, 3'b001);

      // Two ALU ops and a store issue on all three lines at once.
      bus.func_units = 3'b111;
      a = mk(OP_R, 32'd40, 32'd41, 6'd8);
      b = mk(OP_I, 32'd50, 32'd0, 6'd9);
      c = mk(OP_STORE, 32'd60, 32'd61, 6'd10);
      q1.push_back(a); q2.push_back(b); q3.push_back(c);
      dispatch(a, 1'b1, 6'd0, 1'b1, 6'd0);
      dispatch(b, 1'b1, 6'd0, 1'b1, 6'd0);
      dispatch(c, 1'b1, 6'd0, 1'b1, 6'd0);
      bus.func_units = 3'b000;
      @(negedge clk); check("t3b_hold", bus.line_valid, 3'b000);
      @(negedge clk); check("t3b_all", bus.line_valid, 3'b111);

      // ALU0 busy: the single ready ALU op goes to line_2.
      bus.func_units = 3'b001;
      a = mk(OP_R, 32'd70, 32'd71, 6'd11);
      q2.push_back(a);
      dispatch(a, 1'b1, 6'd0, 1'b1, 6'd0);
      @(negedge clk);
      @(negedge clk); check("t5_lv", bus.line_valid, 3'b010);

      // ALU1 busy: ops go one per cycle on line_1 in age order.
      bus.func_units = 3'b010;
      a = mk(OP_R, 32'd80, 32'd81, 6'd12);
      b = mk(OP_R, 32'd90, 32'd91, 6'd13);
      q1.push_back(a); q1.push_back(b);
      dispatch(a, 1'b1, 6'd0, 1'b1, 6'd0);
      dispatch(b, 1'b1, 6'd0, 1'b1, 6'd0);
      @(negedge clk); check("t5b_first", bus.line_valid, 3'b001);
      @(negedge clk); check("t5b_second", bus.line_valid, 3'b001);
      bus.func_units = 3'b000;

      // Unsupported opcode is dropped at dispatch and never issues.
      a = mk(7'b1100011, 32'd1, 32'd2, 6'd50);
      dispatch(a, 1'b1, 6'd0, 1'b1, 6'd0);
      @(negedge clk); check("drop_lv_a", bus.line_valid, 3'b000);
      @(negedge clk); check("drop_lv_b", bus.line_valid, 3'b000);
      check("drop_ready", bus.disp_ready, 1);

      // Fill all eight slots with ops waiting on tag 20; ninth is refused.
      for (int i = 0; i < 8; i++) begin
         a = mk(OP_R, 32'd0, 32'(i), 6'(32 + i));
         ex = a; ex.source_1 = 32'h55;
         if (i % 2 == 0) q1.push_back(ex); else q2.push_back(ex);
         dispatch(a, 1'b0, 6'd20, 1'b1, 6'd0);
      end
      @(negedge clk);
      check("full_ready", bus.disp_ready, 0);
      check("full_lv", bus.line_valid, 3'b000);
      a = mk(OP_R, 32'd1, 32'd1, 6'd60);
      dispatch(a, 1'b1, 6'd0, 1'b1, 6'd0);
      @(negedge clk);
      check("full_ignore_ready", bus.disp_ready, 0);
      check("full_ignore_lv", bus.line_valid, 3'b000);
      bus.cdb_valid = 1'b1; bus.cdb_tag = 6'd20; bus.cdb_value = 32'h55;
      @(posedge clk); #1;
      bus.cdb_valid = 1'b0;
      @(negedge clk); check("full_wake_edge", bus.line_valid, 3'b000);
      @(negedge clk);
      check("full_drain_lv", bus.line_valid, 3'b011);
      check("full_drain_ready", bus.disp_ready, 1);
      repeat (4) @(negedge clk);

      // Reset mid-operation clears entries and lines at once.
      bus.func_units = 3'b111;
      a = mk(OP_R, 32'd1, 32'd2, 6'd61);
      dispatch(a, 1'b1, 6'd0, 1'b1, 6'd0);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_lv", bus.line_valid, 3'b000);
      check("mid_rst_line_1", bus.line_1, 0);
      check("mid_rst_line_2", bus.line_2, 0);
      check("mid_rst_line_3", bus.line_3, 0);
      check("mid_rst_ready", bus.disp_ready, 1);
      @(posedge clk); #1 rst = 1'b0;
      bus.func_units = 3'b000;
      @(negedge clk);
      @(negedge clk); check("mid_rst_no_issue", bus.line_valid, 3'b000);

`ifdef RS_FLUSH_EN
      // Flush drops four held entries; nothing issues afterwards.
      bus.func_units = 3'b111;
      for (int i = 0; i < 4; i++) begin
         a = mk(OP_R, 32'(i), 32'(i), 6'(40 + i));
         dispatch(a, 1'b1, 6'd0, 1'b1, 6'd0);
      end
      bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      bus.func_units = 3'b000;
      @(negedge clk);
      check("flush_lv", bus.line_valid, 3'b000);
      check("flush_ready", bus.disp_ready, 1);
      @(negedge clk); check("flush_no_issue", bus.line_valid, 3'b000);
`else
      // Flush is ignored: held entries still issue.
      bus.func_units = 3'b111;
      a = mk(OP_R, 32'd7, 32'd8, 6'd44);
      b = mk(OP_R, 32'd9, 32'd10, 6'd45);
      q1.push_back(a); q2.push_back(b);
      dispatch(a, 1'b1, 6'd0, 1'b1, 6'd0);
      dispatch(b, 1'b1, 6'd0, 1'b1, 6'd0);
      bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      bus.func_units = 3'b000;
      @(negedge clk); check("noflush_hold", bus.line_valid, 3'b000);
      @(negedge clk); check("noflush_issue", bus.line_valid, 3'b011);
`endif

      // Bounded drain of anything still expected.
      for (int k = 0; k < 20 && (q1.size() + q2.size() + q3.size()) != 0; k++) @(negedge clk);
      #1;
      check("drain_q1", q1.size(), 0);
      check("drain_q2", q2.size(), 0);
      check("drain_q3", q3.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
